// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and
// the baud divider calculation. Used by both the receiver and the transmitter.
package uart_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // 16x oversampling; the mid-bit sample falls on count 7 of the start bit
  localparam int         OVS_RATE = 16;
  localparam logic [3:0] OVS_MID  = 4'd7;
  localparam logic [3:0] OVS_LAST = 4'd15;

  // Clocks per oversample tick, truncated, never below 1
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * OVS_RATE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a free-running divider that produces a one-clk
// tick every DIV clocks. 'restart' realigns the divider to a start edge.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Divider counter: wraps at DIV-1, cleared by reset or a restart request
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its inputs.
    if (!rst || restart) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1, LSB first, 16x oversampled. Delivers bytes through a
// single-entry rdata/rvalid holding register with rack handshake; the line
// is never stalled, so a byte arriving while the register is full is dropped
// and flagged with overrun.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  logic       rxd_meta;
  logic       rxd_sync;
  logic       rxd_prev;
  logic [2:0] state;
  logic [3:0] ovs_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       tick;
  logic       start_edge;
  logic       stop_sample;
  logic       deliver;
  logic       bad_stop;

  // A start edge only counts in IDLE, so a held break never re-triggers
  assign start_edge  = (state == ST_IDLE) && rxd_prev && !rxd_sync;
  assign stop_sample = (state == ST_STOP) && tick && (ovs_cnt == OVS_LAST);
  assign deliver     = stop_sample && rxd_sync;
  assign bad_stop    = stop_sample && !rxd_sync;
  assign busy        = (state != ST_IDLE);

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_edge),
    .tick    (tick)
  );

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Frame FSM: mid-bit sampling driven by the oversample counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ovs_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state   <= ST_START;
            ovs_cnt <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (ovs_cnt == OVS_MID) begin
              // Re-zero at mid start bit so every later sample lands 16 ticks on
              ovs_cnt <= '0;
              bit_cnt <= '0;
              state   <= rxd_sync ? ST_IDLE : ST_DATA;
            end else begin
              ovs_cnt <= ovs_cnt + 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            ovs_cnt <= ovs_cnt + 4'd1;
            if (ovs_cnt == OVS_LAST) begin
              shift <= {rxd_sync, shift[7:1]};
              if (bit_cnt == 3'd7) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            ovs_cnt <= ovs_cnt + 4'd1;
            if (ovs_cnt == OVS_LAST) begin
              state <= rxd_sync ? ST_IDLE : ST_WAIT_IDLE;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (rxd_sync) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register, rvalid/rack handshake and status pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata     <= 8'h00;
      rvalid    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= deliver && rvalid && !rack;
      if (deliver && (!rvalid || rack)) begin
        rdata  <= shift;
        rvalid <= 1'b1;
      end else if (rack) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Directed testbench for uart_recv at 1.6 MHz / 10 kbaud (160 clk per bit).
module tb_uart_recv;

  localparam int BIT_CLKS = 160;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       rxd  = 1'b1;
  logic       rack = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests   = 0;
  int failed  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;

  uart_recv #(
    .CLK_FREQ (1_600_000),
    .BAUD     (10_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rack      (rack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count status pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of an LSB-first frame, one bit-time each
  task automatic drive_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd = frame[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    drive_bits({1'b1, d, 1'b0}, 10);
  endtask

  // Start + data, then set the stop level and return at the stop-bit start
  task automatic send_head(input logic [7:0] d, input logic stop);
    drive_bits({1'b1, d, 1'b0}, 9);
    rxd = stop;
  endtask

  task automatic ack();
    rack = 1'b1;
    wait_clks(1);
    rack = 1'b0;
    wait_clks(1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    wait_clks(4);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    wait_clks(20);

    // 0x55, good stop, rack low: delivered just after mid-stop, then held
    send_head(8'h55, 1'b1);
    wait_clks(78);
    check("a_rvalid_pre_mid", rvalid, 0);
    wait_clks(7);
    check("a_rvalid", rvalid, 1);
    check("a_rdata", rdata, 8'h55);
    wait_clks(400);
    check("a_rvalid_held", rvalid, 1);
    check("a_rdata_held", rdata, 8'h55);
    check("a_no_ferr", fe_cnt, 0);
    ack();
    check("a_rvalid_cleared", rvalid, 0);
    ack();
    check("a_rack_idle_ignored", rvalid, 0);
    check("a_no_overrun", ov_cnt, 0);

    // 0xA3 then 0x0F back-to-back, no rack: second byte lost with overrun
    send_frame(8'hA3);
    check("b_rdata_first", rdata, 8'hA3);
    check("b_rvalid_first", rvalid, 1);
    send_frame(8'h0F);
    wait_clks(40);
    check("b_rdata_kept", rdata, 8'hA3);
    check("b_overrun_once", ov_cnt, 1);
    check("b_rvalid_kept", rvalid, 1);
    ack();
    check("b_rvalid_cleared", rvalid, 0);

    // 40-clk low glitch on idle line: false start
    rxd = 1'b0;
    wait_clks(20);
    check("c_busy_in_glitch", busy, 1);
    wait_clks(20);
    rxd = 1'b1;
    wait_clks(300);
    check("c_busy_after", busy, 0);
    check("c_no_rvalid", rvalid, 0);
    check("c_no_ferr", fe_cnt, 0);

    // 0x3C with bad stop, then a 5-bit-time break, then 0x81
    send_head(8'h3C, 1'b0);
    wait_clks(300);
    check("d_ferr_pulse", fe_cnt, 1);
    check("d_busy_break", busy, 1);
    check("d_no_rvalid", rvalid, 0);
    wait_clks(BIT_CLKS + 5 * BIT_CLKS - 300);
    check("d_busy_break_end", busy, 1);
    check("d_ferr_still_one", fe_cnt, 1);
    rxd = 1'b1;
    wait_clks(10);
    check("d_idle_after_rise", busy, 0);
    wait_clks(BIT_CLKS);
    send_frame(8'h81);
    check("d_rdata_81", rdata, 8'h81);
    check("d_rvalid_81", rvalid, 1);
    check("d_ferr_final", fe_cnt, 1);
    ack();

    // 0x11 held, then rack in the exact delivery cycle of 0x7E
    send_frame(8'h11);
    check("e_rdata_first", rdata, 8'h11);
    send_head(8'h7E, 1'b1);
    wait_clks(82);
    rack = 1'b1;
    wait_clks(1);
    rack = 1'b0;
    wait_clks(5);
    check("e_rdata_7e", rdata, 8'h7E);
    check("e_rvalid", rvalid, 1);
    check("e_no_overrun", ov_cnt, 1);
    wait_clks(80);

    // Reset during bit 4 of 0xFF, then 0x12
    drive_bits({1'b1, 8'hFF, 1'b0}, 5);
    rxd = 1'b1;
    wait_clks(80);
    check("f_busy_mid_frame", busy, 1);
    rst = 1'b0;
    wait_clks(3);
    check("f_rst_rvalid", rvalid, 0);
    check("f_rst_rdata", rdata, 8'h00);
    check("f_rst_busy", busy, 0);
    check("f_rst_frame_err", frame_err, 0);
    check("f_rst_overrun", overrun, 0);
    rst = 1'b1;
    wait_clks(5 * BIT_CLKS);
    check("f_no_delivery", rvalid, 0);
    check("f_idle", busy, 0);
    check("f_no_ferr", fe_cnt, 1);
    send_frame(8'h12);
    check("f_rdata_12", rdata, 8'h12);
    check("f_rvalid_12", rvalid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
